arbitro_control: RTL
====================

ARBITRO_CONTROL -- requirements
Module: arbitro_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6: width of every data word.
REQ-002 SHALL have parameter NUM_IN, default 4: number of input FIFOs; fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fifo_empty, input, NUM_IN: empty flag of each input FIFO.
REQ-006 SHALL have port fifo_data, input, NUM_IN*DATA_WIDTH: read data of each FIFO; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port out_almost_full, input, 2: almost-full flags of destination FIFOs D0 (bit 0) and D1 (bit 1).
REQ-008 SHALL have port pop, output, NUM_IN: one-hot read strobe to the input FIFOs.
REQ-009 SHALL have port data_out, output, DATA_WIDTH: word forwarded to the destination demux.
REQ-010 SHALL have port destiny, output, 1: destination select for data_out (0 = D0, 1 = D1).
REQ-011 SHALL have port push, output, 2: write strobe to D0 (bit 0) or D1 (bit 1).
REQ-012 SHALL have port idle, output, 1: high when no FIFO is requesting and the pipeline is empty.

Function
REQ-013 SHALL implement the FSM states INIT, IDLE and ACTIVE.
REQ-014 SHALL leave INIT for IDLE on the first clock edge with reset low.
REQ-015 SHALL move from IDLE to ACTIVE when any fifo_empty bit is 0.
REQ-016 SHALL move from ACTIVE to IDLE when all fifo_empty bits are 1 and no word is in flight.
REQ-017 SHALL assert pop in cycle N (combinationally from registered state and current inputs) only if the state is ACTIVE, the granted FIFO is not empty and both out_almost_full bits are 0.
REQ-018 SHALL assert at most one pop bit per cycle, and SHALL allow a pop in every cycle.
REQ-019 SHALL treat the input FIFO read data as valid in cycle N+1.
REQ-020 SHALL register the selected word at the end of cycle N+1.
REQ-021 SHALL present data_out, destiny and push during cycle N+2, giving a fixed latency of 2 cycles.
REQ-022 SHALL derive destiny from the MSB of the word (bit DATA_WIDTH-1).
REQ-023 SHALL drive push[destiny] = 1 with the other push bit 0, and push = 2'b00 when no word is delivered.
REQ-024 SHALL hold data_out and destiny at their last delivered values when push = 0.
REQ-025 SHALL stop issuing pops while either almost_full bit is 1, and SHALL still deliver the up-to-2 words already in flight (destination almost_full thresholds therefore leave at least 2 free slots).
REQ-026 SHALL resume pops in the cycle after both almost_full bits return to 0.
REQ-027 SHALL not generate any pop while all FIFOs are empty.
REQ-028 SHALL require each input FIFO's empty flag to reflect a pop by the following cycle.
REQ-029 SHALL drive idle = 1 in IDLE and INIT, and idle = 0 in ACTIVE or with any word in flight.

Reset
REQ-030 SHALL, with reset high at a clock edge, set the state to INIT and set pop = 0, push = 0, data_out = 0, destiny = 0, idle = 1 and the round-robin pointer to 0.
REQ-031 SHALL discard in-flight words and deliver no push in any cycle following a reset edge when reset is asserted mid-operation.

Configuration
REQ-032 SHALL, with ARBITRO_ROUND_ROBIN_EN defined, grant the first non-empty FIFO at or after the pointer in circular order and set the pointer to granted index + 1 (mod 4) after each pop.
REQ-033 SHALL, without ARBITRO_ROUND_ROBIN_EN, use fixed priority (FIFO0 highest, FIFO3 lowest) and keep no pointer.

Verification
REQ-034 SHALL cover: reset, then FIFO1 holding 0x05 -> pop = 0010 in cycle N; push = 01, data_out = 0x05, destiny = 0 in cycle N+2.
REQ-035 SHALL cover: FIFO2 holding 0x25 -> push = 10, destiny = 1, data_out = 0x25 two cycles after the pop.
REQ-036 SHALL cover: all four FIFOs non-empty with ARBITRO_ROUND_ROBIN_EN -> pop sequence 0001, 0010, 0100, 1000, 0001; without the macro -> 0001 repeated until FIFO0 is empty.
REQ-037 SHALL cover: out_almost_full = 01 raised during continuous traffic -> pops stop the same cycle, exactly 2 further pushes occur, pops resume the cycle after the flag clears.
REQ-038 SHALL cover: reset asserted one cycle after a pop -> no push follows, outputs are 0, idle = 1.
REQ-039 SHALL cover: all FIFOs empty for 10 cycles -> pop = 0, push = 0, idle = 1 throughout.

Source files
------------

// File: rtl/arbitro_control.sv
// arbitro_control: pops at most one word per cycle from 4 input FIFOs and forwards it to D0/D1 by its MSB, 2-cycle latency.
// Pops stall while either destination is almost full; define ARBITRO_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module arbitro_control #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_IN     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            fifo_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_data,
  input  logic [1:0]                   out_almost_full,
  output logic [NUM_IN-1:0]            pop,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         destiny,
  output logic [1:0]                   push,
  output logic                         idle
);
  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  destiny_q, destiny_d;
  logic [1:0]            push_q, push_d;
  logic                  idle_q, idle_d;
`ifdef ARBITRO_ROUND_ROBIN_EN
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      rr_idx;
`endif

  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  pop_en;
  logic [DATA_WIDTH-1:0] rd_word;

  // Scan from lowest to highest priority so the highest-priority requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = ~&fifo_empty;
`ifdef ARBITRO_ROUND_ROBIN_EN
    rr_idx  = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      rr_idx = ptr_q + IDX_W'(k);
      if (!fifo_empty[rr_idx]) begin
        gnt_idx = rr_idx;
      end
    end
`else
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (!fifo_empty[k]) begin
        gnt_idx = IDX_W'(k);
      end
    end
`endif
  end

  always_comb begin
    pop_en = (state_q == ACTIVE) && !reset && gnt_vld && (out_almost_full == 2'b00);
    pop    = '0;
    if (pop_en) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  // FIFO read data is valid the cycle after its pop; select it by the remembered grant.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (rd_idx_q == IDX_W'(i)) begin
        rd_word = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = IDLE;
      IDLE:    if (!(&fifo_empty)) state_d = ACTIVE;
      ACTIVE:  if ((&fifo_empty) && !rd_vld_q) state_d = IDLE;
      default: state_d = INIT;
    endcase

    rd_vld_d   = pop_en;
    rd_idx_d   = gnt_idx;
    push_d     = 2'b00;
    data_out_d = data_out_q;
    destiny_d  = destiny_q;
    if (rd_vld_q) begin
      data_out_d = rd_word;
      destiny_d  = rd_word[DATA_WIDTH-1];
      push_d     = rd_word[DATA_WIDTH-1] ? 2'b10 : 2'b01;
    end

    idle_d = (state_d != ACTIVE);

`ifdef ARBITRO_ROUND_ROBIN_EN
    ptr_d = ptr_q;
    if (pop_en) begin
      ptr_d = gnt_idx + IDX_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      data_out_q <= '0;
      destiny_q  <= 1'b0;
      push_q     <= 2'b00;
      idle_q     <= 1'b1;
`ifdef ARBITRO_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      data_out_q <= data_out_d;
      destiny_q  <= destiny_d;
      push_q     <= push_d;
      idle_q     <= idle_d;
`ifdef ARBITRO_ROUND_ROBIN_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign destiny  = destiny_q;
  assign push     = push_q;
  assign idle     = idle_q;

endmodule
